// File: rtl/aes_128_key_expand_wr_pkg.sv
// Shared constants for the AES-128 key-expansion writer: FSM states, rcon and the forward S-box.
package aes_128_key_expand_wr_pkg;

  localparam int unsigned NumRounds = 10;
  localparam int unsigned AddrW     = 4;
  localparam int unsigned RoundW    = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWr0,
    StSub,
    StGen
  } state_e;

  function automatic logic [7:0] rcon(input logic [RoundW-1:0] round);
    logic [7:0] rc;
    rc = 8'h00;
    unique case (round)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // Entry 0 sits in the top byte.
  localparam logic [2047:0] SboxTable = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
    logic [10:0] idx;
    idx = {~x, 3'b000};
    return SboxTable[idx +: 8];
  endfunction

endpackage

// File: rtl/aes_sbox_sync.sv
// Forward AES S-box as a 256x8 registered ROM with one-cycle read latency and no reset.
module aes_sbox_sync
  import aes_128_key_expand_wr_pkg::*;
(
  input  logic       clk_i,
  input  logic [7:0] addr_i,
  output logic [7:0] data_o
);

  logic [7:0] data_q;

  always_ff @(posedge clk_i) begin
    data_q <= sbox_fwd(addr_i);
  end

  assign data_o = data_q;

endmodule

// File: rtl/aes_128_key_expand_wr.sv
// AES-128 key-expansion writer: streams round keys 0..10 onto a single-word key RAM write port.
module aes_128_key_expand_wr
  import aes_128_key_expand_wr_pkg::*;
#(
  parameter int unsigned AddrBase = 0
) (
  input  logic              clk_i,
  input  logic              kill_ni,
  input  logic              start_i,
  input  logic [127:0]      key_in_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              en_wr_o,
  output logic [AddrW-1:0]  addr_wr_o,
  output logic [127:0]      key_round_wr_o
);

  state_e             state_q, state_d;
  logic [RoundW-1:0]  round_q, round_d;
  logic [127:0]       key_q, key_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               en_wr_q, en_wr_d;
  logic [AddrW-1:0]   addr_q, addr_d;
  logic [127:0]       key_wr_q, key_wr_d;

  logic [31:0] rot_w, sub_w, t_w, n0_w, n1_w, n2_w, n3_w;

  // key_q only changes on GEN, so the S-box address is stable across the SUB edge.
  assign rot_w = {key_q[23:0], key_q[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox_sync u_sbox (
      .clk_i  (clk_i),
      .addr_i (rot_w[8*i +: 8]),
      .data_o (sub_w[8*i +: 8])
    );
  end

  assign t_w  = sub_w ^ {rcon(round_q), 24'h000000};
  assign n0_w = key_q[127:96] ^ t_w;
  assign n1_w = key_q[95:64]  ^ n0_w;
  assign n2_w = key_q[63:32]  ^ n1_w;
  assign n3_w = key_q[31:0]   ^ n2_w;

  always_comb begin
    state_d  = state_q;
    round_d  = round_q;
    key_d    = key_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    en_wr_d  = 1'b0;
    addr_d   = addr_q;
    key_wr_d = key_wr_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          key_d    = key_in_i;
          key_wr_d = key_in_i;
          en_wr_d  = 1'b1;
          addr_d   = AddrW'(AddrBase);
          round_d  = RoundW'(1);
          busy_d   = 1'b1;
          state_d  = StWr0;
        end
      end
      StWr0: state_d = StSub;
      StSub: state_d = StGen;
      StGen: begin
        key_d    = {n0_w, n1_w, n2_w, n3_w};
        key_wr_d = {n0_w, n1_w, n2_w, n3_w};
        en_wr_d  = 1'b1;
        addr_d   = AddrW'(AddrBase) + round_q;
        if (round_q == RoundW'(NumRounds)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          round_d = round_q + RoundW'(1);
          state_d = StSub;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge kill_ni) begin
    if (!kill_ni) begin
      state_q  <= StIdle;
      round_q  <= '0;
      key_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      en_wr_q  <= 1'b0;
      addr_q   <= '0;
      key_wr_q <= '0;
    end else begin
      state_q  <= state_d;
      round_q  <= round_d;
      key_q    <= key_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      en_wr_q  <= en_wr_d;
      addr_q   <= addr_d;
      key_wr_q <= key_wr_d;
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign en_wr_o        = en_wr_q;
  assign addr_wr_o      = addr_q;
  assign key_round_wr_o = key_wr_q;

endmodule

// File: tb/tb_aes_128_key_expand_wr.sv
// Bench for aes_128_key_expand_wr: two instances (base 0 and 8) checked every cycle against a
// round-key model built from GF(2^8) arithmetic, plus directed scenario checks.
module tb_aes_128_key_expand_wr;

  localparam logic [127:0] KeyFips = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FipsR1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FipsR10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZeroR1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZeroR10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk;
  logic         kill_n;
  logic         start;
  logic [127:0] key_in;
  logic         busy0, done0, en0, busy8, done8, en8;
  logic [3:0]   addr0, addr8;
  logic [127:0] key0, key8;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int en_cnt = 0;
  int done_cnt = 0;
  int en_cyc[$];
  logic [127:0] mem0 [16];
  logic [127:0] mem8 [16];
  logic [7:0]   sb [256];

  // Model state
  bit           m_active = 1'b0;
  int           m_c = 0;
  logic [127:0] m_key = '0;
  logic         exp_busy = 1'b0, exp_done = 1'b0, exp_en = 1'b0;
  logic [3:0]   exp_addr0 = '0, exp_addr8 = '0;
  logic [127:0] exp_key = '0;

  aes_128_key_expand_wr #(.AddrBase(0)) dut0 (
    .clk_i          (clk),
    .kill_ni        (kill_n),
    .start_i        (start),
    .key_in_i       (key_in),
    .busy_o         (busy0),
    .done_o         (done0),
    .en_wr_o        (en0),
    .addr_wr_o      (addr0),
    .key_round_wr_o (key0)
  );

  aes_128_key_expand_wr #(.AddrBase(8)) dut8 (
    .clk_i          (clk),
    .kill_ni        (kill_n),
    .start_i        (start),
    .key_in_i       (key_in),
    .busy_o         (busy8),
    .done_o         (done8),
    .en_wr_o        (en8),
    .addr_wr_o      (addr8),
    .key_round_wr_o (key8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [134:0] act, input logic [134:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ tmp;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic void emit(input int r);
    exp_en    = 1'b1;
    exp_addr0 = 4'(r);
    exp_addr8 = 4'(8 + r);
    exp_key   = round_key(m_key, r);
  endfunction

  // Model: edge-numbered view of the write schedule.
  initial begin
    forever begin
      @(posedge clk or negedge kill_n);
      if (!kill_n) begin
        m_active = 1'b0; m_c = 0; m_key = '0;
        exp_busy = 1'b0; exp_done = 1'b0; exp_en = 1'b0;
        exp_addr0 = '0; exp_addr8 = '0; exp_key = '0;
      end else begin
        exp_en   = 1'b0;
        exp_done = 1'b0;
        if (!m_active) begin
          if (start) begin
            m_active = 1'b1;
            m_c      = 0;
            m_key    = key_in;
            exp_busy = 1'b1;
            emit(0);
          end
        end else begin
          m_c++;
          if (m_c >= 3 && (m_c % 2) == 1) begin
            emit((m_c - 1) / 2);
            if (m_c == 21) begin
              m_active = 1'b0;
              exp_done = 1'b1;
              exp_busy = 1'b0;
            end
          end
        end
      end
    end
  end

  // Per-cycle compare and write logging.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      chk("cycle_dut0", {busy0, done0, en0, addr0, key0},
          {exp_busy, exp_done, exp_en, exp_addr0, exp_key});
      chk("cycle_dut8", {busy8, done8, en8, addr8, key8},
          {exp_busy, exp_done, exp_en, exp_addr8, exp_key});
      if (en0) begin
        mem0[addr0] = key0;
        en_cnt++;
        en_cyc.push_back(cyc);
      end
      if (en8) mem8[addr8] = key8;
      if (done0) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_log();
    for (int i = 0; i < 16; i++) begin
      mem0[i] = '0;
      mem8[i] = '0;
    end
    en_cnt = 0;
    en_cyc.delete();
  endtask

  task automatic pulse_start(input logic [127:0] k);
    key_in = k;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_done(input bit scramble, input int target);
    for (int i = 0; i < 100 && done_cnt < target; i++) begin
      if (scramble) key_in = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    chk("done_reached", 135'(done_cnt >= target), 135'(1));
    tick();
    tick();
  endtask

  initial begin
    int d0;
    kill_n = 1'b1;
    start  = 1'b0;
    key_in = '0;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
    end
    chk("pin_fips_r1",  round_key(KeyFips, 1),  FipsR1);
    chk("pin_fips_r10", round_key(KeyFips, 10), FipsR10);
    chk("pin_zero_r1",  round_key('0, 1),       ZeroR1);
    chk("pin_zero_r10", round_key('0, 10),      ZeroR10);

    #1 kill_n = 1'b0;
    repeat (3) tick();
    chk("reset_dut0", {busy0, done0, en0, addr0, key0}, '0);
    chk("reset_dut8", {busy8, done8, en8, addr8, key8}, '0);
    kill_n = 1'b1;
    tick();

    // FIPS-197 vector on both bases
    clear_log();
    d0 = done_cnt;
    pulse_start(KeyFips);
    wait_done(1'b0, d0 + 1);
    chk("fips_a0",       mem0[0],  KeyFips);
    chk("fips_a1",       mem0[1],  FipsR1);
    chk("fips_a10",      mem0[10], FipsR10);
    chk("fips_base8_a8", mem8[8],  KeyFips);
    chk("fips_base8_a9", mem8[9],  FipsR1);
    chk("fips_base8_a2", mem8[2],  FipsR10);
    chk("fips_en_count", 135'(en_cnt), 135'(11));
    chk("fips_done_count", 135'(done_cnt - d0), 135'(1));

    // All-zero key with key_in scrambled after acceptance
    clear_log();
    d0 = done_cnt;
    pulse_start('0);
    wait_done(1'b1, d0 + 1);
    chk("zero_a1",  mem0[1],  ZeroR1);
    chk("zero_a10", mem0[10], ZeroR10);
    chk("zero_en_count", 135'(en_cnt), 135'(11));
    for (int i = 0; i < 11 && i < en_cyc.size(); i++)
      chk("zero_en_slot", 135'(en_cyc[i] - en_cyc[0]), 135'(i == 0 ? 0 : 2 * i + 1));

    // start held high: accepted at E0 and E22 only
    clear_log();
    d0 = done_cnt;
    key_in = KeyFips;
    start  = 1'b1;
    repeat (30) tick();
    start  = 1'b0;
    wait_done(1'b0, d0 + 2);
    repeat (25) tick();
    chk("held_en_count", 135'(en_cnt), 135'(22));
    chk("held_done_count", 135'(done_cnt - d0), 135'(2));
    if (en_cyc.size() >= 12) chk("held_period", 135'(en_cyc[11] - en_cyc[0]), 135'(22));
    else chk("held_period", 135'(en_cyc.size()), 135'(12));

    // kill_n low for one cycle at E9
    clear_log();
    pulse_start(KeyFips);
    repeat (8) tick();
    kill_n = 1'b0;
    #1;
    chk("kill_zero_dut0", {busy0, done0, en0, addr0, key0}, '0);
    chk("kill_zero_dut8", {busy8, done8, en8, addr8, key8}, '0);
    tick();
    kill_n = 1'b1;
    d0 = en_cnt;
    repeat (12) tick();
    chk("kill_no_more_en", 135'(en_cnt), 135'(d0));

    clear_log();
    d0 = done_cnt;
    pulse_start(KeyFips);
    wait_done(1'b1, d0 + 1);
    chk("restart_a0",  mem0[0],  KeyFips);
    chk("restart_a1",  mem0[1],  FipsR1);
    chk("restart_a10", mem0[10], FipsR10);
    chk("restart_en_count", 135'(en_cnt), 135'(11));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/aes_128_key_expand_wr.md
# aes_128_key_expand_wr

AES-128 key-expansion writer: accepts a 128-bit cipher key and generates the 11 round keys, rounds 0 to 10, in order. Each round key goes out on a single-word write port that connects directly to the `en_wr`/`addr_wr`/`key_round_wr` inputs of the 3-cycle-round key RAM. It is the producer end of that write interface. The key RAM read side, driven by `key_ready`, is unaffected by this block.

## Interface
- `ADDR_BASE`, default 0: RAM address for round key 0. Round r goes to `ADDR_BASE + r`, modulo 16.
- `clk` in 1: clock, rising edge.
- `kill_n` in 1: reset, asynchronous, active-low.
- `start` in 1: request an expansion of `key_in`. Sampled only when `busy`=0.
- `key_in` in 128: cipher key. Word w0 = [127:96], w3 = [31:0]. Captured on the accepting edge.
- `busy` in/out: out 1: high from the accepting edge until the edge that writes round 10.
- `done` out 1: one-cycle pulse, coincident with the round-10 write.
- `en_wr` out 1: key RAM write strobe, one cycle per round key.
- `addr_wr` out 4: key RAM write address.
- `key_round_wr` out 128: key RAM write data.

## Operation
- FSM states: IDLE, WR0, SUB, GEN.
- IDLE, `start`=1: load key_reg and key_round_wr with `key_in`. Set `en_wr`=1, `addr_wr`=ADDR_BASE, round=1, `busy`=1. Go to WR0.
- WR0: clear `en_wr`. Go to SUB.
- SUB: drive the S-box address inputs with RotWord(w3) = {w3[23:0], w3[31:24]}, one byte per S-box instance. Clear `en_wr`. Go to GEN.
- GEN: the S-box output is valid.
  - t = SubWord(RotWord(w3)) XOR {rcon[round], 24'h0}.
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
  - Register the new key into key_reg and key_round_wr, and set `en_wr`=1, `addr_wr`=ADDR_BASE+round.
  - If round<10: increment round, go to SUB.
  - If round=10: go to IDLE, set `done`=1, and deassert `busy` on the same edge.
- rcon for rounds 1 to 10: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- `start` while `busy`=1 is ignored. It is neither queued nor able to disturb the expansion in progress.
- `key_in` changes after the accepting edge have no effect.
- `kill_n` low at any time, including mid-expansion:
  - Immediate return to IDLE.
  - All outputs and registers go to 0.
  - A partially written key RAM is left as-is. The next full expansion overwrites it.
- `addr_wr` wraps modulo 16. For example, ADDR_BASE=8 writes addresses 8 through 15, then 0 through 2.

## Timing
- Reset values: `busy`=0, `done`=0, `en_wr`=0, `addr_wr`=0, `key_round_wr`=0. All state registers are 0.
- Edge numbering: E0 is the edge on which `start` is accepted.
- Round 0 is written in the cycle after E0.
- Round r (1 to 10) is written in the cycle after edge E(2r+1). Two cycles per round: a synchronous S-box read, then XOR-and-write.
- `en_wr` is high on exactly 11 cycles: after E0, E3, E5, …, E21.
- `en_wr` is low between writes. `addr_wr` and `key_round_wr` hold their values when `en_wr`=0.
- `done` is high in the cycle after E21 only. `busy` is high in the cycles after E0 through E20.
- Back-to-back operation: `start` sampled at E21 is ignored because `busy` is still 1. `start` at E22 is accepted, which gives a minimum period of 22 cycles.
- S-box: 256x8 synchronous ROM, BRAM style, 1-cycle read latency, no output reset.

## Structure
- Shared include holds:
  - the rcon table as a 10-entry localparam function,
  - FSM state encodings,
  - the round count (10) and the address width (4).
- Sub-module `aes_sbox_sync`: one port with address, data out and clock, and a 256-entry registered ROM. Instantiate it 4 times for SubWord. The datapath's forward S-box is shared with it.
- The top level contains the FSM, round counter, key_reg, XOR chain and output registers. It contains no other logic.

## Test plan
- FIPS-197 vector, ADDR_BASE=0: `key_in`=2b7e151628aed2a6abf7158809cf4f3c, then `start`. Required response:
  - addr 0 receives the key.
  - addr 1 receives a0fafe1788542cb123a339392a6c7605.
  - addr 10 receives d014f9a8c9ee2589e13f0cc8b6630ca6.
  - `done` is high only alongside the addr-10 write.
- All-zero key: round 1 = 62636363626363636263636362636363, round 10 = b4ef5bcb3e92e21123e951cf6f8f188e. Count `en_wr` pulses: exactly 11, at E0+1 and E(2r+1)+1.
- `start` held high continuously: expansions start at E0 and E22 only. Expansions do not overlap, and there are no extra `en_wr` pulses.
- ADDR_BASE=8: addresses written are 8 through 15, then 0, 1, 2. Data is identical to the FIPS-197 scenario.
- `kill_n` low for 1 cycle at E9: all outputs are 0 immediately. No further `en_wr` follows. A subsequent `start` produces a full, correct sequence from round 0.
- `key_in` changed every cycle after E0: the written round keys still match the key captured at E0.
